btn_turn_ctrl: RTL and testbench

BTN_TURN_CTRL -- requirements
Module: btn_turn_ctrl

---
 rtl/btn_turn_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_btn_turn_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_turn_ctrl.sv
// Two-button debounce front end plus per-turn countdown timer.
// Each raw button is synchronised, debounced by its own FSM and turned into
// a one-cycle pulse; a prescaled seconds counter reloads on player change,
// on turn_en rising, and after a timeout.

module btn_turn_ctrl_deb #(
  parameter int unsigned DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pressed_i,
  output logic accept_o
);

  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_e;

  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and stability counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; accept_o flags the PRESS_WAIT->HELD transition only
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_i) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          accept_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!pressed_i) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed_i) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

module btn_turn_ctrl #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned DEB_CYC  = 1000000,
  parameter int unsigned TURN_SEC = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_move_n,
  input  logic       btn_select_n,
  input  logic       player,
  input  logic       turn_en,
  output logic       move_pulse,
  output logic       select_pulse,
  output logic       timeout,
  output logic [3:0] sec_left
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [3:0]    SEC_RELOAD = 4'(TURN_SEC);

  logic [1:0]    mv_sync_q, sel_sync_q;
  logic          p_move, p_sel;
  logic          move_acc, sel_acc;
  logic          move_pulse_q, select_pulse_q, timeout_q, timeout_d;
  logic [3:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          player_q, en_q;

  // Two-flop synchronisers on the raw active-low buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv_sync_q  <= '1;
      sel_sync_q <= '1;
    end else begin
      mv_sync_q  <= {mv_sync_q[0], btn_move_n};
      sel_sync_q <= {sel_sync_q[0], btn_select_n};
    end
  end

  assign p_move = ~mv_sync_q[1];
  assign p_sel  = ~sel_sync_q[1];

  btn_turn_ctrl_deb #(.DEB_CYC(DEB_CYC)) u_deb_move (
    .clk      (clk),
    .rst_n    (rst),
    .pressed_i(p_move),
    .accept_o (move_acc)
  );

  btn_turn_ctrl_deb #(.DEB_CYC(DEB_CYC)) u_deb_sel (
    .clk      (clk),
    .rst_n    (rst),
    .pressed_i(p_sel),
    .accept_o (sel_acc)
  );

  // Turn timer next state: reload causes beat the tick, tick at sec 0 times out
  always_comb begin
    presc_d   = presc_q;
    sec_d     = sec_q;
    timeout_d = 1'b0;
    if ((player != player_q) || (turn_en && !en_q)) begin
      presc_d = '0;
      sec_d   = SEC_RELOAD;
    end else if (turn_en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (sec_q == 4'd0) begin
          timeout_d = 1'b1;
          sec_d     = SEC_RELOAD;
        end else begin
          sec_d = sec_q - 4'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Output pulses and timer registers; a colliding move pulse is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_pulse_q   <= 1'b0;
      select_pulse_q <= 1'b0;
      timeout_q      <= 1'b0;
      sec_q          <= SEC_RELOAD;
      presc_q        <= '0;
      player_q       <= player;
      en_q           <= 1'b0;
    end else begin
      move_pulse_q   <= move_acc & ~sel_acc;
      select_pulse_q <= sel_acc;
      timeout_q      <= timeout_d;
      sec_q          <= sec_d;
      presc_q        <= presc_d;
      player_q       <= player;
      en_q           <= turn_en;
    end
  end

  assign move_pulse   = move_pulse_q;
  assign select_pulse = select_pulse_q;
  assign timeout      = timeout_q;
  assign sec_left     = sec_q;

endmodule

// File: tb/tb_btn_turn_ctrl.sv
// Bench for btn_turn_ctrl: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against a behavioural model.

module tb_btn_turn_ctrl;

  localparam int CLK = 10;
  localparam int DEB = 4;
  localparam int TS  = 3;

  logic       clk;
  logic       rst;
  logic       btn_move_n;
  logic       btn_select_n;
  logic       player;
  logic       turn_en;
  logic       move_pulse;
  logic       select_pulse;
  logic       timeout;
  logic [3:0] sec_left;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  btn_turn_ctrl #(.CLK_HZ(CLK), .DEB_CYC(DEB), .TURN_SEC(TS)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_move_n  (btn_move_n),
    .btn_select_n(btn_select_n),
    .player      (player),
    .turn_en     (turn_en),
    .move_pulse  (move_pulse),
    .select_pulse(select_pulse),
    .timeout     (timeout),
    .sec_left    (sec_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button: a debounced level flips once the synchronised level has disagreed
  // with it for DEB+1 consecutive samples; a flip to pressed is an event.
  // Timer: n counts enabled cycles since the last reload; every CLK of them is
  // one elapsed second, and elapsing TS+1 seconds is a timeout.
  bit m_s1, m_s2, s_s1, s_s2;
  bit m_deb, s_deb;
  int m_run, s_run;
  int n;
  int exp_sec;
  bit exp_to, exp_mv, exp_sel;
  bit prev_pl, prev_en;

  function automatic bit deb_step(input bit p, inout bit d, inout int run);
    deb_step = 1'b0;
    if (p != d) begin
      run++;
      if (run == DEB + 1) begin
        d        = p;
        run      = 0;
        deb_step = p;
      end
    end else begin
      run = 0;
    end
  endfunction

  task automatic model_step();
    bit mev, sev;
    if (!rst) begin
      m_s1 = 1; m_s2 = 1; s_s1 = 1; s_s2 = 1;
      m_deb = 0; s_deb = 0; m_run = 0; s_run = 0;
      n = 0; exp_sec = TS; exp_to = 0; exp_mv = 0; exp_sel = 0;
      prev_pl = player; prev_en = 0;
    end else begin
      mev = deb_step(!m_s2, m_deb, m_run);
      sev = deb_step(!s_s2, s_deb, s_run);
      m_s2 = m_s1; m_s1 = btn_move_n;
      s_s2 = s_s1; s_s1 = btn_select_n;
      exp_sel = sev;
      exp_mv  = mev && !sev;
      exp_to  = 0;
      if (player != prev_pl || (turn_en && !prev_en)) begin
        n = 0;
        exp_sec = TS;
      end else if (turn_en) begin
        n++;
        if (n % CLK == 0) begin
          if (n / CLK == TS + 1) begin
            exp_to  = 1;
            n       = 0;
            exp_sec = TS;
          end else begin
            exp_sec = TS - n / CLK;
          end
        end
      end
      prev_pl = player;
      prev_en = turn_en;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  // Per-cycle compare against the model
  initial forever begin
    @(posedge clk);
    #1;
    if (chk_on) begin
      check("model move_pulse", move_pulse, exp_mv);
      check("model select_pulse", select_pulse, exp_sel);
      check("model timeout", timeout, exp_to);
      check("model sec_left", sec_left, exp_sec);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int cnt, cnt2, lat;
    int secs[1:42];
    int tcnt, tat;

    rst = 1; btn_move_n = 1; btn_select_n = 1; player = 0; turn_en = 0;
    #2 rst = 0;
    repeat (3) cyc();
    check("reset move_pulse", move_pulse, 0);
    check("reset select_pulse", select_pulse, 0);
    check("reset timeout", timeout, 0);
    check("reset sec_left", sec_left, 3);
    rst = 1;
    chk_on = 1;
    repeat (2) cyc();

    // move held 20 cycles: exactly one pulse, ~7 cycles after press
    btn_move_n = 0; cnt = 0; lat = 0;
    for (int j = 1; j <= 20; j++) begin
      cyc();
      if (move_pulse) begin cnt++; if (lat == 0) lat = j; end
    end
    check("move single pulse", cnt, 1);
    check_rng("move latency", lat, 6, 8);
    btn_move_n = 1;
    repeat (12) cyc();

    // select bouncing every 2 cycles, then steady press
    cnt = 0;
    for (int seg = 0; seg < 6; seg++) begin
      btn_select_n = (seg % 2 == 1);
      repeat (2) begin cyc(); if (select_pulse) cnt++; end
    end
    check("bounce no early pulse", cnt, 0);
    btn_select_n = 0; lat = 0;
    for (int j = 1; j <= 15; j++) begin
      cyc();
      if (select_pulse) begin cnt++; if (lat == 0) lat = j; end
    end
    check("bounce single pulse", cnt, 1);
    check_rng("bounce latency", lat, 6, 8);
    btn_select_n = 1;
    repeat (12) cyc();

    // both pressed together: select wins, move discarded
    btn_move_n = 0; btn_select_n = 0; cnt = 0; cnt2 = 0;
    for (int j = 1; j <= 15; j++) begin
      cyc();
      if (select_pulse) cnt++;
      if (move_pulse) cnt2++;
    end
    check("both select pulses", cnt, 1);
    check("both move pulses", cnt2, 0);
    btn_move_n = 1; btn_select_n = 1;
    repeat (12) cyc();

    // countdown: turn_en rises, 3,2,1,0 then timeout and reload
    turn_en = 1; tcnt = 0; tat = 0;
    for (int j = 1; j <= 42; j++) begin
      cyc();
      secs[j] = sec_left;
      if (timeout) begin tcnt++; if (tat == 0) tat = j; end
    end
    check("timer sec@10", secs[10], 3);
    check("timer sec@11", secs[11], 2);
    check("timer sec@21", secs[21], 1);
    check("timer sec@31", secs[31], 0);
    check("timer sec@40", secs[40], 0);
    check("timer sec@41", secs[41], 3);
    check("timer timeout count", tcnt, 1);
    check("timer timeout edge", tat, 41);
    turn_en = 0;
    repeat (3) cyc();
    check("timer frozen", sec_left, 3);

    // player change at sec 1, prescaler 9: reload, no timeout
    turn_en = 1;
    for (int j = 1; j <= 30; j++) cyc();
    check("pchg pre sec_left", sec_left, 1);
    player = ~player;
    cyc();
    check("pchg sec_left", sec_left, 3);
    check("pchg timeout", timeout, 0);
    cyc();
    check("pchg next sec_left", sec_left, 3);
    turn_en = 0;
    repeat (2) cyc();

    // reset during PRESS_WAIT with button held
    btn_move_n = 0;
    repeat (4) cyc();
    rst = 0;
    cyc();
    check("rst move_pulse", move_pulse, 0);
    check("rst sec_left", sec_left, 3);
    rst = 1; cnt = 0; lat = 0;
    for (int j = 1; j <= 14; j++) begin
      cyc();
      if (move_pulse) begin cnt++; if (lat == 0) lat = j; end
    end
    check("rst held single pulse", cnt, 1);
    check_rng("rst held latency", lat, 6, 8);
    btn_move_n = 1;
    repeat (12) cyc();

    // randomized traffic, checked by the model
    for (int j = 0; j < 3000; j++) begin
      cyc();
      if ($urandom_range(0, 11) == 0) btn_move_n = ~btn_move_n;
      if ($urandom_range(0, 11) == 0) btn_select_n = ~btn_select_n;
      if ($urandom_range(0, 59) == 0) player = ~player;
      if ($urandom_range(0, 79) == 0) turn_en = ~turn_en;
      if ($urandom_range(0, 999) == 0) begin
        rst = 0;
        cyc();
        rst = 1;
      end
    end
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
